// File: rtl/frame_buffer_write_arbiter.sv
// frame_buffer_write_arbiter
// Shares the single frame_buffer write port between fill_drawer (0), line_drawer (1)
// and symbol_drawer (2). Each drawer owns a one-entry holding slot with a ready
// handshake. A round-robin scheduler drains one full slot per cycle into a
// registered write port, so concurrent drawers never interleave address and data.
module frame_buffer_write_arbiter #(
    parameter int  HOR_ACTIVE_PIXELS = 640,
    parameter int  VER_ACTIVE_PIXELS = 480,
    localparam int PIXELS_COUNT      = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int ADDR_WIDTH        = $clog2(PIXELS_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  fill_write_enable,
    input  logic [ADDR_WIDTH-1:0] fill_write_addr,
    input  logic                  fill_write_data,
    output logic                  fill_write_ready,

    input  logic                  line_write_enable,
    input  logic [ADDR_WIDTH-1:0] line_write_addr,
    input  logic                  line_write_data,
    output logic                  line_write_ready,

    input  logic                  symbol_write_enable,
    input  logic [ADDR_WIDTH-1:0] symbol_write_addr,
    input  logic                  symbol_write_data,
    output logic                  symbol_write_ready,

    output logic                  fb_write_enable,
    output logic [ADDR_WIDTH-1:0] fb_write_addr,
    output logic                  fb_write_data,
    output logic                  idle,
    output logic                  addr_error
);

    localparam int                NUM_PORTS  = 3;
    // One extra bit so the limit is representable even when PIXELS_COUNT is a power of two.
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(PIXELS_COUNT);

    // Next port index after 'base', 'step' positions around the ring of three ports.
    function automatic logic [1:0] rr_index(input logic [1:0] base, input int unsigned step);
        int unsigned sum;
        sum = (32'(base) + step) % NUM_PORTS;
        return sum[1:0];
    endfunction

    // Requests gathered into index-addressable form.
    logic [NUM_PORTS-1:0]  wr_en;
    logic [NUM_PORTS-1:0]  wr_data;
    logic [ADDR_WIDTH-1:0] wr_addr [NUM_PORTS];

    assign wr_en      = {symbol_write_enable, line_write_enable, fill_write_enable};
    assign wr_data    = {symbol_write_data, line_write_data, fill_write_data};
    assign wr_addr[0] = fill_write_addr;
    assign wr_addr[1] = line_write_addr;
    assign wr_addr[2] = symbol_write_addr;

    // Slot and output-port state.
    logic [NUM_PORTS-1:0]  full_q, full_d;
    logic [NUM_PORTS-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] addr_d [NUM_PORTS];
    logic [1:0]            last_grant_q, last_grant_d;
    logic                  fb_we_q, fb_we_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic                  fb_data_q, fb_data_d;
    logic                  addr_error_q, addr_error_d;

    logic [NUM_PORTS-1:0]  granted;
    logic [NUM_PORTS-1:0]  ready;
    logic [NUM_PORTS-1:0]  accept;
    logic [NUM_PORTS-1:0]  in_range;

    // Round-robin grant: first full slot searching from the port after the last winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        granted = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            if (granted == '0 && full_q[rr_index(last_grant_q, k)]) begin
                granted[rr_index(last_grant_q, k)] = 1'b1;
            end
        end
    end

    // A slot can take a new entry when empty or when it is being drained this cycle.
    assign ready  = {NUM_PORTS{~rst}} & (~full_q | granted);
    assign accept = wr_en & ready;

    // Address range check per port.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_range[i] = ({1'b0, wr_addr[i]} < ADDR_LIMIT);
        end
    end

    // Next state: drain the granted slot into the fb registers, then load accepted requests.
    always_comb begin
        full_d       = full_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        addr_error_d = addr_error_q;

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (granted[i]) begin
                fb_we_d      = 1'b1;
                fb_addr_d    = addr_q[i];
                fb_data_d    = data_q[i];
                full_d[i]    = 1'b0;
                last_grant_d = 2'(i);
            end
        end

        // Loading after the drain lets a slot be emptied and refilled on the same edge.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (accept[i]) begin
                if (in_range[i]) begin
                    full_d[i] = 1'b1;
                    addr_d[i] = wr_addr[i];
                    data_d[i] = wr_data[i];
                end else begin
                    addr_error_d = 1'b1;
                end
            end
        end
    end

    // Control state and the registered write port, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            full_q       <= '0;
            last_grant_q <= 2'd2;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            last_grant_q <= last_grant_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            addr_error_q <= addr_error_d;
        end
    end

    // Slot payload storage.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is only ever read while its full bit is set.
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign fill_write_ready   = ready[0];
    assign line_write_ready   = ready[1];
    assign symbol_write_ready = ready[2];

    assign fb_write_enable = fb_we_q;
    assign fb_write_addr   = fb_addr_q;
    assign fb_write_data   = fb_data_q;
    assign addr_error      = addr_error_q;
    assign idle            = ~|full_q & ~fb_we_q;

endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// Self-checking bench for frame_buffer_write_arbiter: a vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based reference model.
module tb_frame_buffer_write_arbiter;

    localparam int HOR = 640;
    localparam int VER = 480;
    localparam int PC  = HOR * VER;
    localparam int AW  = $clog2(PC);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        en_v;
    logic [2:0]        data_v;
    logic [AW-1:0]     addr_v [3];
    wire  [2:0]        rdy_v;
    wire               fb_we;
    wire  [AW-1:0]     fb_addr;
    wire               fb_data;
    wire               idle;
    wire               addr_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buffer_write_arbiter #(
        .HOR_ACTIVE_PIXELS(HOR),
        .VER_ACTIVE_PIXELS(VER)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fill_write_enable  (en_v[0]),
        .fill_write_addr    (addr_v[0]),
        .fill_write_data    (data_v[0]),
        .fill_write_ready   (rdy_v[0]),
        .line_write_enable  (en_v[1]),
        .line_write_addr    (addr_v[1]),
        .line_write_data    (data_v[1]),
        .line_write_ready   (rdy_v[1]),
        .symbol_write_enable(en_v[2]),
        .symbol_write_addr  (addr_v[2]),
        .symbol_write_data  (data_v[2]),
        .symbol_write_ready (rdy_v[2]),
        .fb_write_enable    (fb_we),
        .fb_write_addr      (fb_addr),
        .fb_write_data      (fb_data),
        .idle               (idle),
        .addr_error         (addr_error)
    );

    typedef struct {
        logic [2:0]    en;
        logic [AW-1:0] a0, a1, a2;
        logic [2:0]    d;
        logic [2:0]    exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic          exp_data;
        logic          exp_idle;
        logic          exp_err;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [2:0] en, input int a0, input int a1, input int a2,
                                input logic [2:0] d, input logic [2:0] rdy, input logic we,
                                input int ea, input logic ed, input logic eidle, input logic eerr);
        vec_t v;
        v.en = en; v.a0 = AW'(a0); v.a1 = AW'(a1); v.a2 = AW'(a2); v.d = d;
        v.exp_ready = rdy; v.exp_we = we; v.exp_addr = AW'(ea); v.exp_data = ed;
        v.exp_idle = eidle; v.exp_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_v = 3'b000; data_v = 3'b000;
        for (int p = 0; p < 3; p++) addr_v[p] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        check("rst_ready", rdy_v, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_idle", idle, 1);
        check("post_rst_ready", rdy_v, 3'b111);
        check("post_rst_we", fb_we, 0);
        check("post_rst_addr", fb_addr, 0);
        check("post_rst_err", addr_error, 0);
    endtask

    // Reference model state (queues of pending writes, at most one per port).
    wr_t  mq [3][$];
    int   m_last;
    logic m_we, m_data, m_err;
    logic [AW-1:0] m_addr;

    initial begin
        logic [2:0]    hold;
        logic [2:0]    exp_rdy;
        int            pick;
        int            n;
        int            ln, sn;
        int            total, bad;
        bit            got_idle;
        wr_t           w;
        logic [AW-1:0] seq_addr [$];
        int            wcount [int];
        bit            wval [int];

        idle_inputs();

        // Vector table: three-way contention, out-of-range rejection, top-address boundary.
        vecs[0]  = mk(3'b111, 100, 200, 300,    3'b101, 3'b111, 0, 0,      0, 0, 0);
        vecs[1]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b001, 1, 100,    1, 0, 0);
        vecs[2]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b011, 1, 200,    0, 0, 0);
        vecs[3]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 1, 300,    1, 0, 0);
        vecs[4]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 0, 300,    1, 1, 0);
        vecs[5]  = mk(3'b100, 0, 0, PC,         3'b000, 3'b111, 0, 300,    1, 1, 1);
        vecs[6]  = mk(3'b001, 5, 0, 0,          3'b000, 3'b111, 0, 300,    1, 0, 1);
        vecs[7]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 1, 5,      0, 0, 1);
        vecs[8]  = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 0, 5,      0, 1, 1);
        vecs[9]  = mk(3'b100, 0, 0, PC - 1,     3'b100, 3'b111, 0, 5,      0, 0, 1);
        vecs[10] = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 1, PC - 1, 1, 0, 1);
        vecs[11] = mk(3'b000, 0, 0, 0,          3'b000, 3'b111, 0, PC - 1, 1, 1, 1);

        tick();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            en_v = vecs[i].en; data_v = vecs[i].d;
            addr_v[0] = vecs[i].a0; addr_v[1] = vecs[i].a1; addr_v[2] = vecs[i].a2;
            #1;
            check($sformatf("vec%0d_ready", i), rdy_v, vecs[i].exp_ready);
            tick();
            check($sformatf("vec%0d_we", i), fb_we, vecs[i].exp_we);
            check($sformatf("vec%0d_addr", i), fb_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_data", i), fb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
            check($sformatf("vec%0d_err", i), addr_error, vecs[i].exp_err);
        end
        idle_inputs();

        // Fill alone streams addresses 0..9: ready stays high, strobes start 2 edges later.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k < 10) begin
                en_v = 3'b001; addr_v[0] = AW'(k); data_v = 3'b001;
            end else begin
                idle_inputs();
            end
            #1;
            check($sformatf("stream_ready%0d", k), rdy_v[0], 1);
            tick();
            check($sformatf("stream_we%0d", k), fb_we, (k >= 1 && k <= 10) ? 1 : 0);
            if (k >= 1 && k <= 10) begin
                check($sformatf("stream_addr%0d", k), fb_addr, k - 1);
                check($sformatf("stream_data%0d", k), fb_data, 1);
            end
        end

        // Line and symbol stream together: strobes alternate line/symbol, each in order.
        do_reset();
        ln = 0; sn = 0;
        seq_addr.delete();
        for (int c = 0; c < 40 && seq_addr.size() < 12; c++) begin
            en_v = {sn < 6, ln < 6, 1'b0};
            addr_v[1] = AW'(1000 + ln); addr_v[2] = AW'(2000 + sn);
            data_v = 3'b000;
            #1;
            if (en_v[1] && rdy_v[1]) ln++;
            if (en_v[2] && rdy_v[2]) sn++;
            tick();
            if (fb_we) seq_addr.push_back(fb_addr);
        end
        idle_inputs();
        check("pair_count", seq_addr.size(), 12);
        for (int i = 0; i < 12 && i < seq_addr.size(); i++) begin
            check($sformatf("pair_addr%0d", i), seq_addr[i], (i % 2 == 0) ? 1000 + i / 2 : 2000 + i / 2);
        end

        // Reset while two slots are full, after a line grant that would favour symbol next.
        do_reset();
        en_v = 3'b010; addr_v[1] = AW'(7);
        tick();
        idle_inputs();
        tick();
        check("mid_line_we", fb_we, 1);
        check("mid_line_addr", fb_addr, 7);
        en_v = 3'b101; addr_v[0] = AW'(11); addr_v[2] = AW'(22); data_v = 3'b001;
        #1;
        check("mid_offer_ready", rdy_v, 3'b111);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", rdy_v, 3'b000);
        tick();
        check("mid_rst_we0", fb_we, 0);
        tick();
        check("mid_rst_we1", fb_we, 0);
        rst = 1'b0;
        #1;
        check("mid_rel_idle", idle, 1);
        check("mid_rel_ready", rdy_v, 3'b111);
        en_v = 3'b101; addr_v[0] = AW'(33); addr_v[2] = AW'(44); data_v = 3'b001;
        tick();
        idle_inputs();
        check("mid_rel_no_stale", fb_we, 0);
        tick();
        check("mid_first_we", fb_we, 1);
        check("mid_first_addr", fb_addr, 33);
        tick();
        check("mid_second_addr", fb_addr, 44);

        // 640-pixel fill burst, then wait for idle and audit the written pixels.
        do_reset();
        n = 0; total = 0;
        for (int c = 0; c < 2000 && n < 640; c++) begin
            en_v = 3'b001; addr_v[0] = AW'(n); data_v = {2'b00, n[1]};
            #1;
            if (rdy_v[0]) n++;
            tick();
            if (fb_we) begin
                wcount[int'(fb_addr)]++;
                wval[int'(fb_addr)] = fb_data;
                total++;
            end
        end
        idle_inputs();
        got_idle = 0;
        for (int c = 0; c < 20; c++) begin
            if (idle) begin
                got_idle = 1;
                break;
            end
            tick();
            if (fb_we) begin
                wcount[int'(fb_addr)]++;
                wval[int'(fb_addr)] = fb_data;
                total++;
            end
        end
        check("burst_idle", got_idle, 1);
        check("burst_total", total, 640);
        bad = 0;
        for (int a = 0; a < 640; a++) begin
            if (!wcount.exists(a) || wcount[a] != 1 || wval[a] != a[1]) bad++;
        end
        check("burst_bad_pixels", bad, 0);

        // Randomized traffic against the queue model.
        do_reset();
        for (int p = 0; p < 3; p++) mq[p].delete();
        m_last = 2; m_we = 0; m_addr = '0; m_data = 0; m_err = 0;
        hold = 3'b000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 3; p++) begin
                if (!hold[p] && $urandom_range(0, 2) != 0) begin
                    hold[p] = 1'b1;
                    if ($urandom_range(0, 15) == 0) addr_v[p] = AW'(PC + $urandom_range(0, 200000));
                    else                            addr_v[p] = AW'($urandom_range(0, PC - 1));
                    data_v[p] = 1'($urandom_range(0, 1));
                end
            end
            en_v = hold;
            #1;
            pick = -1;
            for (int k = 1; k <= 3; k++) begin
                if (pick < 0 && mq[(m_last + k) % 3].size() != 0) pick = (m_last + k) % 3;
            end
            for (int p = 0; p < 3; p++) exp_rdy[p] = (mq[p].size() == 0) || (pick == p);
            check("rand_ready", rdy_v, exp_rdy);
            if (pick >= 0) begin
                w = mq[pick].pop_front();
                m_we = 1; m_addr = w.addr; m_data = w.data; m_last = pick;
            end else begin
                m_we = 0;
            end
            for (int p = 0; p < 3; p++) begin
                if (en_v[p] && exp_rdy[p]) begin
                    hold[p] = 1'b0;
                    if (int'(addr_v[p]) < PC) mq[p].push_back('{addr: addr_v[p], data: data_v[p]});
                    else                      m_err = 1;
                end
            end
            tick();
            check("rand_we", fb_we, m_we);
            if (m_we) begin
                check("rand_addr", fb_addr, m_addr);
                check("rand_data", fb_data, m_data);
            end
            check("rand_idle", idle, (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && !m_we));
            check("rand_err", addr_error, m_err);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
